// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared types and constants for the operand entry block.
//   state_t  - editor state (EDIT_A, EDIT_B, SHOW)
//   action_t - single action chosen per cycle by button priority
//   REPEAT_*_DEF - default auto-repeat timing in clk cycles
package operand_entry_pkg;

  typedef enum logic [1:0] {EDIT_A, EDIT_B, SHOW} state_t;

  typedef enum logic [2:0] {NONE, CLR, SUM, DIFF, SEL_A, SEL_B, INC, DEC} action_t;

  localparam int REPEAT_DELAY_DEF = 25_000_000;
  localparam int REPEAT_RATE_DEF  = 5_000_000;

  // Counter width able to hold the larger of the two repeat intervals.
  function automatic int cnt_width(input int delay, input int rate);
    return $clog2(((delay > rate) ? delay : rate) + 1);
  endfunction

endpackage

// File: rtl/operand_entry_btn_repeat.sv
// btn_repeat: press generator for one button.
//   clk     - clock
//   btn     - level button state, active-high
//   reset   - sync active-high reset (auto-repeat build only)
//   restart - a higher-priority action happened; restart repeat timing
//             (auto-repeat build only)
//   press   - one-cycle pulse: rising edge, or an auto-repeat step
// Optional feature macro: OPERAND_AUTOREPEAT_EN (adds delay/rate counter).
module btn_repeat
  import operand_entry_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk,
`ifdef OPERAND_AUTOREPEAT_EN
  input  logic reset,
  input  logic restart,
`endif
  input  logic btn,
  output logic press
);

  logic prev;
  logic edge_p;

  // Previous sample always follows the input, including during reset, so a
  // button held through reset never looks like a fresh press.
  always_ff @(posedge clk) prev <= btn;

  assign edge_p = btn & ~prev;

`ifdef OPERAND_AUTOREPEAT_EN
  localparam int CW = cnt_width(REPEAT_DELAY, REPEAT_RATE);

  logic [CW-1:0] cnt;
  logic          first;  // still waiting for the initial (longer) delay
  logic          armed;  // hold began with a real edge after reset
  logic          rpt;

  assign rpt   = btn & prev & armed &
                 (cnt == (first ? CW'(REPEAT_DELAY) : CW'(REPEAT_RATE)));
  assign press = edge_p | rpt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      first <= 1'b1;
      armed <= 1'b0;
    end else if (!btn) begin
      cnt   <= '0;
      first <= 1'b1;
      armed <= 1'b0;
    end else if (edge_p || restart) begin
      // cnt counts cycles since the timing origin; origin cycle is 0.
      if (edge_p) armed <= 1'b1;
      cnt   <= CW'(1);
      first <= 1'b1;
    end else if (rpt) begin
      cnt   <= CW'(1);
      first <= 1'b0;
    end else if (armed) begin
      cnt   <= cnt + CW'(1);
    end
  end
`else
  assign press = edge_p;
`endif

endmodule

// File: rtl/operand_entry.sv
// operand_entry: NES-button driven operand editor for an adder/subtractor.
//   clk, reset          - clock, sync active-high reset
//   up/down/left/right/select/a_but/b_but - level buttons, active-high
//   a_op, b_op          - operands (registered)
//   cin, slct           - 1/1 selects difference, 0/0 selects sum
//   edit_b              - 1 while editing operand B
//   show                - 1 while a result is displayed
// Optional feature macro: OPERAND_AUTOREPEAT_EN (hold-to-repeat on up/down).
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             select,
  input  logic             a_but,
  input  logic             b_but,
  output logic [WIDTH-1:0] a_op,
  output logic [WIDTH-1:0] b_op,
  output logic             cin,
  output logic             slct,
  output logic             edit_b,
  output logic             show
);

  state_t           state, state_n;
  action_t          act;
  logic [WIDTH-1:0] a_n, b_n;
  logic             cin_n, slct_n;
  logic [4:0]       prev;
  logic             sel_p, a_p, b_p, l_p, r_p, up_p, dn_p;

  always_ff @(posedge clk) prev <= {select, a_but, b_but, left, right};

  assign sel_p = select & ~prev[4];
  assign a_p   = a_but  & ~prev[3];
  assign b_p   = b_but  & ~prev[2];
  assign l_p   = left   & ~prev[1];
  assign r_p   = right  & ~prev[0];

`ifdef OPERAND_AUTOREPEAT_EN
  logic hi_up, hi_dn;
  assign hi_up = sel_p | a_p | b_p | l_p | r_p;
  assign hi_dn = hi_up | up_p;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk(clk), .reset(reset), .restart(hi_up), .btn(up), .press(up_p));
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
    .clk(clk), .reset(reset), .restart(hi_dn), .btn(down), .press(dn_p));
`else
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk(clk), .btn(up), .press(up_p));
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
    .clk(clk), .btn(down), .press(dn_p));
`endif

  // One action per cycle; lower-priority edges in the same cycle are lost.
  always_comb begin
    act = NONE;
    if      (sel_p) act = CLR;
    else if (a_p)   act = SUM;
    else if (b_p)   act = DIFF;
    else if (l_p)   act = SEL_A;
    else if (r_p)   act = SEL_B;
    else if (up_p)  act = INC;
    else if (dn_p)  act = DEC;
  end

  always_comb begin
    state_n = state;
    a_n     = a_op;
    b_n     = b_op;
    cin_n   = cin;
    slct_n  = slct;
    unique case (act)
      CLR: begin
        state_n = EDIT_A;
        a_n     = '0;
        b_n     = '0;
        cin_n   = 1'b0;
        slct_n  = 1'b0;
      end
      SUM: begin
        state_n = SHOW;
        cin_n   = 1'b0;
        slct_n  = 1'b0;
      end
      DIFF: begin
        state_n = SHOW;
        cin_n   = 1'b1;
        slct_n  = 1'b1;
      end
      SEL_A: state_n = EDIT_A;
      // Leaving SHOW always returns to A, whichever direction was pressed.
      SEL_B: state_n = (state == SHOW) ? EDIT_A : EDIT_B;
      INC: begin
        if (state == EDIT_A) a_n = a_op + WIDTH'(1);
        if (state == EDIT_B) b_n = b_op + WIDTH'(1);
      end
      DEC: begin
        if (state == EDIT_A) a_n = a_op - WIDTH'(1);
        if (state == EDIT_B) b_n = b_op - WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EDIT_A;
      a_op   <= '0;
      b_op   <= '0;
      cin    <= 1'b0;
      slct   <= 1'b0;
      edit_b <= 1'b0;
      show   <= 1'b0;
    end else begin
      state  <= state_n;
      a_op   <= a_n;
      b_op   <= b_n;
      cin    <= cin_n;
      slct   <= slct_n;
      edit_b <= (state_n == EDIT_B);
      show   <= (state_n == SHOW);
    end
  end

endmodule
